hwt_golden_monitor: RTL and testbench
=====================================

HWT_GOLDEN_MONITOR -- requirements
Module: hwt_golden_monitor

Interface
REQ-001 The block SHALL have parameter THRESH, default 3: mismatch count that raises the alarm; legal range 1..2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the mismatch and sample counters.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port en, input, 1 bit: monitoring enable; a sample is valid only when en=1.
REQ-006 Ports a, b, c, d, input, 1 bit each: stimulus applied to the 4-input logic block under test.
REQ-007 Port y_obs, input, 1 bit: output observed from the block under test in the same cycle as a..d.
REQ-008 Port clr, input, 1 bit: synchronous clear of the alarm, the counters and the FSM.
REQ-009 Port mismatch, output, 1 bit: one-cycle pulse flagging a compare failure.
REQ-010 Port alarm, output, 1 bit: sticky trojan-activity alarm.
REQ-011 Port err_cnt, output, CNT_W bits: saturating count of mismatches.
REQ-012 Port smp_cnt, output, CNT_W bits: saturating count of valid samples.
REQ-013 Port state, output, 2 bits: FSM state (IDLE=00, MONITOR=01, ALERT=10; 11 unused).

Function
REQ-014 Golden function SHALL be exp = d AND ((a AND b) OR c).
REQ-015 Stage 1 SHALL register a, b, c, d, y_obs and a valid bit. valid = en AND (state != ALERT) AND NOT clr.
REQ-016 Stage 2 SHALL compare registered exp against registered y_obs. mismatch SHALL rise exactly 2 clocks after the sampled edge, only when valid=1 and exp != y_obs.
REQ-017 smp_cnt SHALL increment by 1 for each stage-2 valid sample and SHALL saturate at all-ones.
REQ-018 err_cnt SHALL increment by 1 on each mismatch pulse and SHALL saturate at all-ones.
REQ-019 FSM IDLE -> MONITOR SHALL occur on the first clock with en=1 and clr=0.
REQ-020 FSM MONITOR -> IDLE SHALL occur when en=0. Counters hold; samples already in the pipeline still complete and count.
REQ-021 FSM MONITOR -> ALERT SHALL occur on the clock where the err_cnt increment reaches THRESH. alarm SHALL assert in that same registered update, i.e. the cycle after the mismatch pulse.
REQ-022 ALERT SHALL be sticky regardless of en. While in ALERT no new samples SHALL enter the pipeline, and err_cnt/smp_cnt SHALL freeze after in-flight samples retire.
REQ-023 clr=1 in any state SHALL, on the next edge, set state=IDLE, alarm=0, err_cnt=0, smp_cnt=0, mismatch=0, and flush both pipeline valid bits.
REQ-024 If clr and a mismatch arrive in the same cycle, clr SHALL win: no count, no alarm.
REQ-025 If clr and en are both 1, the FSM SHALL go to IDLE; it enters MONITOR on the following clock if en is still 1.
REQ-026 Mismatches arriving while the FSM is IDLE (pipeline drain) SHALL count but SHALL NOT trigger ALERT. ALERT evaluation SHALL occur only in MONITOR.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0, state SHALL be IDLE, and pipeline valid bits SHALL be 0, asynchronously and independent of clk.
REQ-028 Reset SHALL be deasserted synchronously by the environment. The first edge after release SHALL behave as the IDLE rule.
REQ-029 Reset asserted mid-operation (MONITOR or ALERT) SHALL discard in-flight samples with no mismatch pulse afterwards.

Verification
REQ-030 Clean run: en=1, 16 vectors covering all a..d with y_obs = golden -> smp_cnt=16, err_cnt=0, mismatch never 1, state=01.
REQ-031 Single fault: {a,b,c,d}=1101 with y_obs=0 -> mismatch=1 exactly 2 cycles later, err_cnt=1, alarm=0.
REQ-032 Threshold: 3 faulty vectors (THRESH=3) -> alarm=1 and state=10 one cycle after the 3rd pulse; further faulty vectors leave err_cnt=3.
REQ-033 Clear/collision: clr asserted in the same cycle as the 3rd mismatch pulse -> err_cnt=0, alarm=0, state=00.
REQ-034 Saturation (CNT_W=4, THRESH=15, 20 valid samples) -> smp_cnt=15 with no wrap.
REQ-035 Async reset in ALERT mid-cycle -> alarm=0 and state=00 immediately, with no mismatch pulse after release.

Source files
------------

// File: rtl/hwt_golden_monitor.sv
// hwt_golden_monitor
//   Run-time monitor for a 4-input logic block. Each enabled cycle it captures
//   the block's inputs (a..d) and its observed output (y_obs). Two cycles later
//   it compares the observed output against the golden function
//   d & ((a & b) | c). Mismatches are counted. When THRESH mismatches have
//   been seen while monitoring, a sticky alarm is raised.
//
// Parameters
//   THRESH   mismatch count that raises the alarm (1 .. 2**CNT_W-1)
//   CNT_W    width of the mismatch and sample counters
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       monitoring enable; a sample is taken only while en=1
//   a..d     stimulus seen by the block under test
//   y_obs    block output observed in the same cycle as a..d
//   clr      synchronous clear of the alarm, the counters, the FSM and the pipeline
//   mismatch one-cycle pulse, raised 2 clocks after a failing sample is captured
//   alarm    sticky trojan-activity alarm
//   err_cnt  saturating mismatch count
//   smp_cnt  saturating valid-sample count
//   state    FSM state: IDLE=00, MONITOR=01, ALERT=10
module hwt_golden_monitor #(
    parameter int unsigned THRESH = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             y_obs,
    input  logic             clr,
    output logic             mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        ALERT   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

    state_t fsm;

    // Stage 1: raw capture
    logic s1_valid;
    logic s1_a, s1_b, s1_c, s1_d, s1_y;

    // Stage 2: golden value next to the observed value
    logic s2_valid;
    logic s2_exp, s2_y;

    assign state = fsm;

    // Data registers carry no control meaning; only the valid bits are
    // flushed by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a   <= 1'b0;
            s1_b   <= 1'b0;
            s1_c   <= 1'b0;
            s1_d   <= 1'b0;
            s1_y   <= 1'b0;
            s2_exp <= 1'b0;
            s2_y   <= 1'b0;
        end else begin
            s1_a   <= a;
            s1_b   <= b;
            s1_c   <= c;
            s1_d   <= d;
            s1_y   <= y_obs;
            s2_exp <= s1_d & ((s1_a & s1_b) | s1_c);
            s2_y   <= s1_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            mismatch <= 1'b0;
            alarm    <= 1'b0;
            err_cnt  <= '0;
            smp_cnt  <= '0;
        end else if (clr) begin
            // clr takes priority over any pulse arriving in the same cycle
            fsm      <= IDLE;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            mismatch <= 1'b0;
            alarm    <= 1'b0;
            err_cnt  <= '0;
            smp_cnt  <= '0;
        end else begin
            s1_valid <= en && (fsm != ALERT);
            s2_valid <= s1_valid;
            mismatch <= s2_valid && (s2_exp != s2_y);

            if (s2_valid && (smp_cnt != '1))
                smp_cnt <= smp_cnt + CNT_W'(1);

            // Counting follows the registered pulse, so the alarm lands one
            // cycle after the pulse that reaches the threshold.
            if (mismatch && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);

            case (fsm)
                IDLE: begin
                    if (en)
                        fsm <= MONITOR;
                end
                MONITOR: begin
                    // Threshold is only evaluated while monitoring; pulses
                    // draining during IDLE still count but cannot alarm.
                    if (mismatch && (err_cnt == THRESH_M1)) begin
                        fsm   <= ALERT;
                        alarm <= 1'b1;
                    end else if (!en) begin
                        fsm <= IDLE;
                    end
                end
                ALERT: begin
                    fsm <= ALERT;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwt_golden_monitor.sv
// tb_hwt_golden_monitor
//   Directed bench for hwt_golden_monitor. A default instance (THRESH=3,
//   CNT_W=8) covers the main behaviour. A second instance (THRESH=15,
//   CNT_W=4) shares the stimulus and is used for counter saturation.
module tb_hwt_golden_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       a, b, c, d;
    logic       y_obs;
    logic       clr;

    logic       mismatch;
    logic       alarm;
    logic [7:0] err_cnt;
    logic [7:0] smp_cnt;
    logic [1:0] state;

    logic       sat_mismatch;
    logic       sat_alarm;
    logic [3:0] sat_err_cnt;
    logic [3:0] sat_smp_cnt;
    logic [1:0] sat_state;

    int unsigned n_chk;
    int unsigned n_pass;

    hwt_golden_monitor #(.THRESH(3), .CNT_W(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .y_obs    (y_obs),
        .clr      (clr),
        .mismatch (mismatch),
        .alarm    (alarm),
        .err_cnt  (err_cnt),
        .smp_cnt  (smp_cnt),
        .state    (state)
    );

    hwt_golden_monitor #(.THRESH(15), .CNT_W(4)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .y_obs    (y_obs),
        .clr      (clr),
        .mismatch (sat_mismatch),
        .alarm    (sat_alarm),
        .err_cnt  (sat_err_cnt),
        .smp_cnt  (sat_smp_cnt),
        .state    (sat_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v = {a,b,c,d}
    function automatic logic gold(input logic [3:0] v);
        return v[0] & ((v[3] & v[2]) | v[1]);
    endfunction

    task automatic set_vec(input logic [3:0] v, input logic yv);
        a     = v[3];
        b     = v[2];
        c     = v[1];
        d     = v[0];
        y_obs = yv;
    endtask

    task automatic do_clr();
        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Three faulty 1101 samples followed by golden ones; returns just after
    // the edge on which the third pulse is visible (E4).
    task automatic three_faults();
        en = 1'b1;
        set_vec(4'b1101, 1'b0);
        tick();
        tick();
        tick();
        set_vec(4'b1101, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        logic [3:0] v;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        set_vec(4'b0000, 1'b0);

        // Reset state
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_smp", 32'(smp_cnt), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Clean run over all 16 input combinations
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_vec(v, gold(v));
            tick();
            chk("clean_mismatch", 32'(mismatch), 32'd0);
        end
        chk("clean_state", 32'(state), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clean_drain_mismatch", 32'(mismatch), 32'd0);
        end
        chk("clean_smp", 32'(smp_cnt), 32'd16);
        chk("clean_err", 32'(err_cnt), 32'd0);

        // Single fault: 1101 should give 1, observed 0
        do_clr();
        en = 1'b1;
        set_vec(4'b1101, 1'b0);
        tick();
        en = 1'b0;
        set_vec(4'b0000, 1'b0);
        tick();
        chk("single_mm_e1", 32'(mismatch), 32'd0);
        tick();
        chk("single_mm_e2", 32'(mismatch), 32'd1);
        tick();
        chk("single_mm_e3", 32'(mismatch), 32'd0);
        chk("single_err", 32'(err_cnt), 32'd1);
        chk("single_alarm", 32'(alarm), 32'd0);

        // Threshold reached while monitoring
        do_clr();
        three_faults();
        chk("thr_mm3", 32'(mismatch), 32'd1);
        chk("thr_err_before", 32'(err_cnt), 32'd2);
        chk("thr_alarm_before", 32'(alarm), 32'd0);
        tick();
        chk("thr_alarm", 32'(alarm), 32'd1);
        chk("thr_state", 32'(state), 32'd2);
        chk("thr_err", 32'(err_cnt), 32'd3);
        set_vec(4'b1101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("alert_mismatch", 32'(mismatch), 32'd0);
        end
        chk("alert_err_frozen", 32'(err_cnt), 32'd3);
        chk("alert_smp_frozen", 32'(smp_cnt), 32'd6);
        chk("alert_sticky", 32'(state), 32'd2);

        // clr collides with the third mismatch pulse
        do_clr();
        three_faults();
        chk("coll_mm3", 32'(mismatch), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("coll_err", 32'(err_cnt), 32'd0);
        chk("coll_alarm", 32'(alarm), 32'd0);
        chk("coll_state", 32'(state), 32'd0);
        chk("coll_smp", 32'(smp_cnt), 32'd0);
        tick();
        chk("coll_reenter", 32'(state), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("coll_drain_mismatch", 32'(mismatch), 32'd0);
        end
        chk("coll_err_after", 32'(err_cnt), 32'd0);

        // Saturation on the narrow instance
        do_clr();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = 4'(i);
            set_vec(v, gold(v));
            tick();
        end
        en = 1'b0;
        tick();
        tick();
        tick();
        chk("sat_smp", 32'(sat_smp_cnt), 32'd15);
        chk("sat_err", 32'(sat_err_cnt), 32'd0);
        chk("wide_smp", 32'(smp_cnt), 32'd20);

        // Async reset while in ALERT
        do_clr();
        three_faults();
        tick();
        chk("ar_alert", 32'(state), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_alarm_now", 32'(alarm), 32'd0);
        chk("ar_state_now", 32'(state), 32'd0);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_post_mismatch", 32'(mismatch), 32'd0);
        end

        // Async reset while faulty samples are in flight in MONITOR
        en = 1'b1;
        set_vec(4'b1101, 1'b0);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_mon_state", 32'(state), 32'd0);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_mon_mismatch", 32'(mismatch), 32'd0);
        end
        chk("ar_mon_err", 32'(err_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
